dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port synchronous data memory between the core's MEM-stage load/store port and an external port used for debug and loader accesses. The core port supplies funct3 and a byte address; the block performs byte-lane alignment and load extension. The block sits between the MEM stage and data memory, and the core treats `core_req_i & ~core_gnt_o` as its MEM-stage stall.

## Interface
- `DATA_WIDTH`, 32, data path width
- `ADDR_WIDTH`, `DATA_MEM_ADDR_WIDTH` (10), memory word-index width
- `STARVE_LIMIT`, 4, consecutive losing cycles before the external port is forced to win (fairness build only)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `core_req_i` in 1: core access request, held until granted
- `core_we_i` in 1: 1 = store
- `core_addr_i` in `DATA_WIDTH`: byte address
- `core_wdata_i` in `DATA_WIDTH`: store data, right-aligned
- `core_funct3_i` in 3: load/store funct3 per package constants
- `core_gnt_o` out 1: core access accepted this cycle
- `core_rvalid_o` out 1: core load data valid
- `core_rdata_o` out `DATA_WIDTH`: extended load data
- `core_err_o` out 1: misaligned access, valid with `core_rvalid_o`
- `ext_req_i` in 1: external request, held until granted
- `ext_we_i` in 1: 1 = write
- `ext_addr_i` in `ADDR_WIDTH`: word index
- `ext_wdata_i` in `DATA_WIDTH`: write data
- `ext_be_i` in 4: byte enables
- `ext_gnt_o` out 1: external access accepted
- `ext_rvalid_o` out 1: external read data valid
- `ext_rdata_o` out `DATA_WIDTH`: raw word
- `mem_en_o` out 1: memory access strobe
- `mem_we_o` out 4: byte write enables
- `mem_addr_o` out `ADDR_WIDTH`: word index
- `mem_wdata_o` out `DATA_WIDTH`: lane-aligned write data
- `mem_rdata_i` in `DATA_WIDTH`: read word, valid one cycle after a read strobe

## Operation
- Grant decision:
  - Grants are combinational from the current requests and the fairness state.
  - At most one grant per cycle.
  - The core has priority by default.
  - A granted access drives `mem_*` in the same cycle.
- Core addressing: word index = `core_addr_i[ADDR_WIDTH+1:2]`; lane = `addr[1:0]`.
- Stores:
  - SB: `we = 1 << lane`, data replicated into lane.
  - SH: `we = 4'b0011 << lane`.
  - SW: `we = 4'hF`.
- Loads:
  - Loads issue `mem_en_o = 1`, `mem_we_o = 0`.
  - The registered lane and funct3 select and extend the returned data.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned accesses (half with `lane[0] = 1`, or word with `lane != 0`):
  - The request is granted but not issued: `mem_en_o = 0`.
  - Next cycle: `core_rvalid_o = 1`, `core_err_o = 1`, `core_rdata_o = 0`.
  - This applies to stores as well.
- Response FSM (owner of the in-flight read), with states IDLE, RESP_CORE, RESP_EXT, RESP_ERR:
  - A granted read or misaligned access moves to the matching RESP state.
  - Otherwise the FSM goes to IDLE.
  - A new grant may coincide with a response cycle, so back-to-back reads run at 1 per cycle.
- Writes produce no rvalid.
- An undefined funct3 is treated as a word access.

## Timing
- Grant latency: 0 cycles (same cycle as the request).
- Read latency: `rvalid` exactly 1 cycle after the grant, as a single-cycle pulse.
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - The starvation counter is 0.
  - Registered lane/funct3 are 0.
- Asserting reset mid-access discards the pending response; no rvalid follows reset release.
- If a request is dropped before it is granted, no access occurs.

## Configuration
- `DMEM_ARB_FAIR_EN` defined:
  - A counter increments on each cycle with `ext_req_i & ~ext_gnt_o`, saturating at `STARVE_LIMIT`.
  - When the counter equals `STARVE_LIMIT`, the external port wins arbitration.
  - The counter clears on an external grant.
- `DMEM_ARB_FAIR_EN` undefined: strict core priority, and no counter is instantiated.

## Structure
- Shared package `core_pkg` additions:
  - `arb_owner_e {OWN_NONE, OWN_CORE, OWN_EXT, OWN_ERR}`
  - `localparam DMEM_STARVE_LIMIT = 4`
- Sub-module `lsu_align`, purely combinational:
  - Store side: lane shift and byte-enable generation.
  - Load side: extraction and extension.
  - Misalignment detection.
- The arbiter owns the FSM, counter and grant logic.

## Test plan
- Core SW `0xDEADBEEF` @ `0x10`:
  - `mem_we_o = 4'hF`, `mem_addr_o = 4`.
  - A following LW @ `0x10` gives `core_rvalid_o` one cycle after the grant with `core_rdata_o = 0xDEADBEEF`.
- Core SB `0x000000A5` @ `0x13`:
  - `mem_we_o = 4'b1000`, `mem_wdata_o[31:24] = 0xA5`.
  - LB @ `0x13` returns `0xFFFFFFA5`; LBU returns `0x000000A5`.
- Both ports requesting continuously:
  - Without the macro, `ext_gnt_o` stays 0.
  - With `DMEM_ARB_FAIR_EN` and `STARVE_LIMIT = 4`, the core wins cycles 0–3 and ext wins cycle 4, then the pattern repeats.
- Core LH @ `0x21`:
  - `core_gnt_o = 1`, `mem_en_o = 0`.
  - Next cycle: `core_rvalid_o = 1`, `core_err_o = 1`, `core_rdata_o = 0`.
- External back-to-back reads of words 5 and 6 with memory holding `0x11` and `0x22`: `ext_rvalid_o` is high two consecutive cycles with data `0x11` then `0x22`.
- `rst_n` pulsed low in the cycle after a core read grant: no `core_rvalid_o` after release, and all outputs are 0 during reset.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core constants, load/store funct3 encodings and data-memory arbiter types.
package core_pkg;

    localparam int DATA_MEM_ADDR_WIDTH = 10;
    localparam int DMEM_STARVE_LIMIT   = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_EXT, OWN_ERR} arb_owner_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

    // Unknown funct3 encodings fall through to a word access.
    function automatic acc_size_e acc_size(input logic we, input logic [2:0] f3);
        if (we)
            return f3 == F3_B ? SZ_B : f3 == F3_H ? SZ_H : SZ_W;
        return (f3 == F3_B || f3 == F3_BU) ? SZ_B : (f3 == F3_H || f3 == F3_HU) ? SZ_H : SZ_W;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane placement and byte enables for stores, extraction and extension for loads,
// and misalignment detection for core accesses.
module lsu_align
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [1:0]            lane,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata_lane,
    output logic                  misaligned,
    input  logic [2:0]            rfunct3,
    input  logic [1:0]            rlane,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] load_data
);

    acc_size_e             size;
    acc_size_e             rsize;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  sext;

    always_comb begin
        size       = acc_size(we, funct3);
        misaligned = (size == SZ_H && lane[0]) || (size == SZ_W && lane != 2'd0);
        be         = size == SZ_B ? 4'b0001 << lane : size == SZ_H ? 4'b0011 << lane : 4'hF;
        wdata_lane = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
        rsize      = acc_size(1'b0, rfunct3);
        sext       = rfunct3 == F3_B || rfunct3 == F3_H;
        shifted    = rdata >> {rlane, 3'b000};
        load_data  = rsize == SZ_B ? {{(DATA_WIDTH-8){sext & shifted[7]}}, shifted[7:0]}
                   : rsize == SZ_H ? {{(DATA_WIDTH-16){sext & shifted[15]}}, shifted[15:0]}
                   : shifted;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store port and an external
// debug/loader port. Define DMEM_ARB_FAIR_EN to let a starved external port win after STARVE_LIMIT lost cycles.
module dmem_arbiter
    import core_pkg::*;
#(
`ifdef DMEM_ARB_FAIR_EN
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT,
`endif
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = DATA_MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [DATA_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    input  logic [2:0]            core_funct3_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    output logic                  core_err_o,
    input  logic                  ext_req_i,
    input  logic                  ext_we_i,
    input  logic [ADDR_WIDTH-1:0] ext_addr_i,
    input  logic [DATA_WIDTH-1:0] ext_wdata_i,
    input  logic [3:0]            ext_be_i,
    output logic                  ext_gnt_o,
    output logic                  ext_rvalid_o,
    output logic [DATA_WIDTH-1:0] ext_rdata_o,
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    arb_owner_e            state;
    arb_owner_e            nxt;
    logic [1:0]            rlane;
    logic [2:0]            rfunct3;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  misaligned;
    logic                  ext_win;
    logic                  core_issue;
    logic                  unused_addr;

    assign unused_addr = ^core_addr_i[DATA_WIDTH-1:ADDR_WIDTH+2];

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .we         (core_we_i),
        .funct3     (core_funct3_i),
        .lane       (core_addr_i[1:0]),
        .wdata      (core_wdata_i),
        .be         (be),
        .wdata_lane (wdata_lane),
        .misaligned (misaligned),
        .rfunct3    (rfunct3),
        .rlane      (rlane),
        .rdata      (mem_rdata_i),
        .load_data  (load_data)
    );

`ifdef DMEM_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            starve <= '0;
        else if (ext_gnt_o)
            starve <= '0;
        else if (ext_req_i && starve != LIMIT)
            starve <= starve + SW'(1);

    assign ext_win = starve == LIMIT;
`else
    assign ext_win = 1'b0;
`endif

    // Grants are held off during reset so every output reads zero while rst_n is low.
    always_comb begin
        ext_gnt_o   = rst_n && ext_req_i && (!core_req_i || ext_win);
        core_gnt_o  = rst_n && core_req_i && !ext_gnt_o;
        core_issue  = core_gnt_o && !misaligned;
        mem_en_o    = core_issue || ext_gnt_o;
        mem_we_o    = core_issue && core_we_i ? be : ext_gnt_o && ext_we_i ? ext_be_i : 4'h0;
        mem_addr_o  = core_gnt_o ? core_addr_i[ADDR_WIDTH+1:2] : ext_gnt_o ? ext_addr_i : '0;
        mem_wdata_o = core_issue ? wdata_lane : ext_gnt_o ? ext_wdata_i : '0;
        nxt         = core_gnt_o && misaligned ? OWN_ERR
                    : core_gnt_o && !core_we_i ? OWN_CORE
                    : ext_gnt_o && !ext_we_i   ? OWN_EXT
                    : OWN_NONE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= OWN_NONE;
            rlane         <= '0;
            rfunct3       <= '0;
            core_rvalid_o <= 1'b0;
            core_err_o    <= 1'b0;
            ext_rvalid_o  <= 1'b0;
        end else begin
            state         <= nxt;
            core_rvalid_o <= nxt == OWN_CORE || nxt == OWN_ERR;
            core_err_o    <= nxt == OWN_ERR;
            ext_rvalid_o  <= nxt == OWN_EXT;
            if (core_gnt_o) begin
                rlane   <= core_addr_i[1:0];
                rfunct3 <= core_funct3_i;
            end
        end

    assign core_rdata_o = state == OWN_CORE ? load_data : '0;
    assign ext_rdata_o  = state == OWN_EXT ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a byte-addressed
// reference memory; fairness expectations follow DMEM_ARB_FAIR_EN.
module tb_dmem_arbiter;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [2:0]  core_funct3 = '0;
    logic        core_gnt, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [9:0]  ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic [3:0]  ext_be = '0;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem_words [1024];
    logic [7:0]  ref_b [4096];
    int          n_chk = 0, n_fail = 0;
    logic [31:0] rd, ra, rw;
    logic        exp_ext, prev_ext;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_funct3_i(core_funct3), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
        .core_rdata_o(core_rdata), .core_err_o(core_err),
        .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
        .ext_be_i(ext_be), .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always @(posedge clk)
        if (mem_en) begin
            mem_rdata <= mem_words[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem_words[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic we, input logic [2:0] f3);
        if (we) return f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [2:0] f3);
        int n;
        logic [31:0] v;
        n = nbytes(1'b0, f3);
        v = '0;
        for (int k = 0; k < n; k++) v |= 32'(ref_b[int'(a) + k]) << (8*k);
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [9:0] w);
        return {ref_b[4*int'(w)+3], ref_b[4*int'(w)+2], ref_b[4*int'(w)+1], ref_b[4*int'(w)]};
    endfunction

    task automatic outputs_zero(input string tag);
        check({tag, "_ctl"}, {12'd0, core_gnt, core_rvalid, core_err, ext_gnt, ext_rvalid, mem_en, mem_we, mem_addr}, 32'd0);
        check({tag, "_core_rdata"}, core_rdata, 32'd0);
        check({tag, "_ext_rdata"}, ext_rdata, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic core_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] r);
        int n, ln;
        logic mis;
        logic [3:0] we_exp;
        logic [31:0] mask;
        n = nbytes(we, f3);
        ln = int'(a[1:0]);
        mis = (ln % n) != 0;
        we_exp = (we && !mis) ? 4'(((1 << n) - 1) << ln) : 4'h0;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{we_exp[b]}};
        check("core_rvalid_idle", core_rvalid, 0);
        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = wd;
        #1;
        check("core_gnt", core_gnt, 1);
        check("core_ext_gnt", ext_gnt, 0);
        check("core_mem_en", mem_en, !mis);
        check("core_mem_we", mem_we, we_exp);
        if (!mis) check("core_mem_addr", mem_addr, a[11:2]);
        if (we_exp != 0) check("core_mem_wdata", mem_wdata & mask, (wd << (8*ln)) & mask);
        step;
        core_req = 1'b0;
        if (we && !mis) for (int k = 0; k < n; k++) ref_b[int'(a[11:0]) + k] = wd[8*k +: 8];
        check("core_rvalid", core_rvalid, !we || mis);
        check("core_err", core_err, mis);
        if (!we || mis) check("core_rdata", core_rdata, mis ? 32'd0 : ref_load(a[11:0], f3));
        r = core_rdata;
        step;
    endtask

    task automatic ext_op(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] r);
        check("ext_rvalid_idle", ext_rvalid, 0);
        ext_req = 1'b1; ext_we = we; ext_addr = wa; ext_wdata = wd; ext_be = be;
        #1;
        check("ext_gnt", ext_gnt, 1);
        check("ext_core_gnt", core_gnt, 0);
        check("ext_mem_en", mem_en, 1);
        check("ext_mem_we", mem_we, we ? be : 4'h0);
        check("ext_mem_addr", mem_addr, wa);
        if (we) check("ext_mem_wdata", mem_wdata, wd);
        step;
        ext_req = 1'b0;
        check("ext_rvalid", ext_rvalid, !we);
        if (!we) check("ext_rdata", ext_rdata, ref_word(wa));
        else for (int b = 0; b < 4; b++) if (be[b]) ref_b[4*int'(wa) + b] = wd[8*b +: 8];
        r = ext_rdata;
        step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_words[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_b[4*i + b] = mem_words[i][8*b +: 8];
        end
        step;
        core_req = 1'b1; ext_req = 1'b1;
        #1;
        outputs_zero("reset");
        core_req = 1'b0; ext_req = 1'b0;
        step;
        rst_n = 1'b1;
        step;

        core_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
        core_op(1'b0, 3'd2, 32'h10, 32'h0, rd);
        check("lw_deadbeef", rd, 32'hDEADBEEF);
        core_op(1'b1, 3'd0, 32'h13, 32'h000000A5, rd);
        core_op(1'b0, 3'd0, 32'h13, 32'h0, rd);
        check("lb_a5", rd, 32'hFFFFFFA5);
        core_op(1'b0, 3'd4, 32'h13, 32'h0, rd);
        check("lbu_a5", rd, 32'h000000A5);
        core_op(1'b0, 3'd1, 32'h21, 32'h0, rd);
        check("lh_mis_rdata", rd, 32'h0);
        core_op(1'b1, 3'd2, 32'h22, 32'h12345678, rd);

        // Both ports request reads every cycle.
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'd2; core_addr = 32'h40;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'd7;
        prev_ext = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
`ifdef DMEM_ARB_FAIR_EN
            exp_ext = (i % 5) == 4;
`else
            exp_ext = 1'b0;
`endif
            check("arb_ext_gnt", ext_gnt, exp_ext);
            check("arb_core_gnt", core_gnt, !exp_ext);
            if (i > 0) begin
                check("arb_core_rvalid", core_rvalid, !prev_ext);
                check("arb_ext_rvalid", ext_rvalid, prev_ext);
            end
            prev_ext = exp_ext;
            step;
        end
        core_req = 1'b0; ext_req = 1'b0;
        step;

        ext_op(1'b1, 10'd5, 32'h11, 4'hF, rd);
        ext_op(1'b1, 10'd6, 32'h22, 4'hF, rd);
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'd5;
        #1;
        check("b2b_gnt0", ext_gnt, 1);
        step;
        ext_addr = 10'd6;
        check("b2b_rvalid0", ext_rvalid, 1);
        check("b2b_rdata0", ext_rdata, 32'h11);
        #1;
        check("b2b_gnt1", ext_gnt, 1);
        step;
        ext_req = 1'b0;
        check("b2b_rvalid1", ext_rvalid, 1);
        check("b2b_rdata1", ext_rdata, 32'h22);
        step;
        check("b2b_rvalid_end", ext_rvalid, 0);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rw = $urandom;
            if (ra[31]) ra[11:4] = 8'h0;
            if ($urandom_range(0, 3) == 0)
                ext_op(1'($urandom), ra[13:4], rw, 4'($urandom), rd);
            else
                core_op(1'($urandom), 3'($urandom), ra, rw, rd);
        end

        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'd2; core_addr = 32'h10;
        #1;
        check("rst_pre_gnt", core_gnt, 1);
        step;
        rst_n = 1'b0; ext_req = 1'b1;
        #1;
        outputs_zero("mid_reset");
        core_req = 1'b0; ext_req = 1'b0;
        step;
        step;
        rst_n = 1'b1;
        step;
        check("post_rst_core_rvalid", core_rvalid, 0);
        check("post_rst_ext_rvalid", ext_rvalid, 0);
        step;
        check("post_rst_core_rvalid2", core_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
